phase_readout: RTL and testbench

- Downstream consumer of the coupled-oscillator array. Samples the NUM_OSC asynchronous oscillator phase outputs in the clk domain and compares each one to oscillator 0, the phase reference.
- Counts per-oscillator mismatches over a programmable window and resolves each oscillator to a binary spin by majority.
- Exposes spins, status and (optionally) raw counts through a registered read port on the same 32-bit address map as the array's weight writes.

---
 rtl/phase_readout.sv | 131 +++++++++++++
 tb/tb_phase_readout.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/phase_readout.sv
// Samples NUM_OSC async oscillator phases, counts mismatches against osc 0 over a window and
// resolves spins by majority; registered read port. Macro PHASE_READOUT_CNT_EN exposes live counters.
module phase_readout #(
  parameter int          NUM_OSC = 8,
  parameter int          CNT_W   = 16,
  parameter logic [31:0] ADDR    = 32'h0001_0000
) (
  input  logic               clk,
  input  logic               axi_rstn,
  input  logic [NUM_OSC-1:0] osc_in,
  input  logic               start,
  input  logic [CNT_W-1:0]   window_len,
  output logic               busy,
  output logic               done,
  output logic [NUM_OSC-1:0] spins,
  input  logic               rd_en,
  input  logic [31:0]        rd_addr,
  output logic               rd_valid,
  output logic [31:0]        rd_data
);

  typedef enum logic [1:0] {IDLE, SAMPLE, RESOLVE} state_e;

  state_e             state_q, state_d;
  logic [NUM_OSC-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [NUM_OSC-1:0] spins_q, spins_d;
  logic [CNT_W-1:0]   win_q, win_d, rem_q, rem_d;
  logic [CNT_W-1:0]   cnt_q [1:NUM_OSC-1];
  logic [CNT_W-1:0]   cnt_d [1:NUM_OSC-1];
  logic               done_q, done_d, sticky_q, sticky_d;
  logic               rd_valid_q, rd_valid_d;
  logic [31:0]        rd_data_q, rd_data_d, off;
  logic               in_sample, start_ok, status_rd;

  // done_q keeps busy high for the result cycle so a start there is dropped
  assign in_sample = (state_q == SAMPLE);
  assign busy      = (state_q != IDLE) | done_q;
  assign start_ok  = start & ~busy;
  assign done      = done_q;
  assign spins     = spins_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;

  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      state_q    <= IDLE;
      sync1_q    <= '0;
      sync2_q    <= '0;
      spins_q    <= '0;
      win_q      <= '0;
      rem_q      <= '0;
      done_q     <= 1'b0;
      sticky_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      for (int i = 1; i < NUM_OSC; i++) cnt_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      spins_q    <= spins_d;
      win_q      <= win_d;
      rem_q      <= rem_d;
      done_q     <= done_d;
      sticky_q   <= sticky_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = SAMPLE;
      SAMPLE:  if (rem_q == CNT_W'(1)) state_d = RESOLVE;
      RESOLVE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sync1_d = osc_in;
    sync2_d = sync1_q;
    win_d   = win_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    spins_d = spins_q;
    done_d  = (state_q == RESOLVE);

    if (start_ok) begin
      win_d = (window_len == '0) ? CNT_W'(1) : window_len;
      rem_d = win_d;
      for (int i = 1; i < NUM_OSC; i++) cnt_d[i] = '0;
    end

    if (in_sample) begin
      rem_d = rem_q - CNT_W'(1);
      for (int i = 1; i < NUM_OSC; i++)
        cnt_d[i] = cnt_q[i] + CNT_W'(sync2_q[i] ^ sync2_q[0]);
    end

    // Strict majority at CNT_W+1 bits; a tie resolves to 0
    if (state_q == RESOLVE) begin
      spins_d = '0;
      for (int i = 1; i < NUM_OSC; i++)
        spins_d[i] = ({cnt_q[i], 1'b0} > {1'b0, win_q});
    end
  end

  always_comb begin
    off        = rd_addr - ADDR;
    status_rd  = rd_en && (off == 32'd4);
    sticky_d   = (state_q == RESOLVE) | (sticky_q & ~status_rd);
    rd_valid_d = rd_en;
    rd_data_d  = '0;
    if (rd_en) begin
      case (off)
        32'd0:   rd_data_d = 32'(spins_q);
        32'd4:   rd_data_d = {29'b0, sticky_q, busy, in_sample};
        32'd8:   rd_data_d = 32'(win_q);
        default: rd_data_d = '0;
      endcase
`ifdef PHASE_READOUT_CNT_EN
      for (int i = 1; i < NUM_OSC; i++)
        if (off == 32'(12 + 4 * i)) rd_data_d = 32'(cnt_q[i]);
`endif
    end
  end

endmodule

// File: tb/tb_phase_readout.sv
// Directed bench for phase_readout: cycle-level reference model plus hand-computed checks.
module tb_phase_readout;

  localparam int          N  = 8;
  localparam int          CW = 16;
  localparam logic [31:0] A  = 32'h0001_0000;

  logic          clk = 1'b0, axi_rstn = 1'b0, start = 1'b0, rd_en = 1'b0;
  logic [N-1:0]  osc_in = '0;
  logic [CW-1:0] window_len = '0;
  logic [31:0]   rd_addr = '0;
  logic          busy, done, rd_valid;
  logic [N-1:0]  spins;
  logic [31:0]   rd_data;

  int tests = 0, fails = 0;

  phase_readout dut (
    .clk(clk), .axi_rstn(axi_rstn), .osc_in(osc_in), .start(start), .window_len(window_len),
    .busy(busy), .done(done), .spins(spins), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: n counts clock edges, hist[n] is the osc value captured at edge n.
  // A start accepted at edge E samples hist[E-1 .. E+win-2] and publishes at edge E+win+1.
  int           n = 0;
  logic [N-1:0] hist [0:8191];
  bit           m_have = 0, m_sticky = 0;
  int           m_E = 0, m_win = 0;
  logic [N-1:0] m_spins = '0, e_spins = '0;
  logic         e_busy = 0, e_done = 0, e_rdv = 0;
  logic [31:0]  e_rdd = '0;

  initial for (int i = 0; i < 8192; i++) hist[i] = '0;

  function automatic int mis(input int i, input int k);
    int s = 0;
    for (int j = 1; j <= k; j++) s += int'(hist[m_E + j - 2][i] ^ hist[m_E + j - 2][0]);
    return s;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input bit pb, input bit ps);
    logic [31:0] off;
    off = a - A;
    if (off == 32'd0) return 32'(m_spins);
    if (off == 32'd4) return {29'b0, m_sticky, pb, ps};
    if (off == 32'd8) return 32'(m_win);
`ifdef PHASE_READOUT_CNT_EN
    for (int i = 1; i < N; i++)
      if (m_have && off == 32'(12 + 4 * i))
        return 32'(mis(i, (n - 1 - m_E < m_win) ? n - 1 - m_E : m_win));
`endif
    return 32'd0;
  endfunction

  always @(posedge clk) begin : mdl
    bit pb, ps, clr, setd;
    n++;
    hist[n] = axi_rstn ? osc_in : '0;
    if (!axi_rstn) begin
      m_have = 0; m_E = 0; m_win = 0; m_sticky = 0; m_spins = '0; e_rdv = 0; e_rdd = '0;
    end else begin
      pb    = m_have && n >= m_E + 1 && n <= m_E + m_win + 2;
      ps    = m_have && n >= m_E + 1 && n <= m_E + m_win;
      e_rdv = rd_en;
      e_rdd = rd_en ? model_read(rd_addr, pb, ps) : '0;
      clr   = rd_en && ((rd_addr - A) == 32'd4);
      setd  = m_have && n == m_E + m_win + 1;
      if (setd) begin
        m_spins = '0;
        for (int i = 1; i < N; i++) m_spins[i] = (2 * mis(i, m_win) > m_win);
      end
      m_sticky = setd || (m_sticky && !clr);
      if (!pb && start) begin
        m_have = 1; m_E = n; m_win = (window_len == '0) ? 1 : int'(window_len);
      end
    end
    e_busy  = m_have && n >= m_E && n <= m_E + m_win + 1;
    e_done  = m_have && n == m_E + m_win + 1;
    e_spins = m_spins;
  end

  always @(negedge clk) begin
    if (axi_rstn && n > 0) begin
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("spins", 32'(spins), 32'(e_spins));
      chk("rd_valid", 32'(rd_valid), 32'(e_rdv));
      if (e_rdv) chk("rd_data", rd_data, e_rdd);
    end
  end

  task automatic cyc(input int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic do_start(input logic [CW-1:0] len, output int e);
    start = 1'b1; window_len = len;
    cyc(1);
    e = n; start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int de);
    de = -1;
    for (int c = 0; c < budget; c++) begin
      cyc(1);
      if (done) begin de = n; break; end
    end
    if (de < 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    rd_en = 1'b1; rd_addr = a;
    cyc(1);
    rd_en = 1'b0;
    chk("rd_valid_next", 32'(rd_valid), 32'd1);
    d = rd_data;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int e, de, pulses;
    logic [31:0] d;

    cyc(3);
    axi_rstn = 1'b1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_spins", 32'(spins), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);

    // Constant phases: bits 1 and 3 oppose the reference for every sample
    osc_in = 8'b0000_1010; cyc(3);
    do_start(16, e); wait_done(40, de);
    chk("lat_win16", 32'(de - e + 1), 32'd18);   // start cycle is the one before edge e
    chk("spins_const", 32'(spins), 32'h0A);
`ifdef PHASE_READOUT_CNT_EN
    rd(A + 32'd16, d); chk("cnt1", d, 32'd16);
    rd(A + 32'd20, d); chk("cnt2", d, 32'd0);
`endif
    cyc(2);

    // Reset at sample 40 of a 100-sample window
    do_start(100, e); cyc(20);
    rd(A + 32'd4, d); chk("status_in_sample", 32'(d[1:0]), 32'd3);
    cyc(19);
    axi_rstn = 1'b0; #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_spins", 32'(spins), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    cyc(2); axi_rstn = 1'b1; cyc(1);
    do_start(16, e); wait_done(40, de);
    chk("lat_after_rst", 32'(de - e + 1), 32'd18);
    chk("spins_after_rst", 32'(spins), 32'h0A);
    cyc(2);

    // osc[3] mismatches on exactly m of 16 samples: 8 is a tie, 9 a majority
    osc_in = '0; cyc(3);
    for (int m = 8; m <= 9; m++) begin
      do_start(16, e); cyc(1);
      osc_in[3] = 1'b1; cyc(m); osc_in[3] = 1'b0;
      wait_done(40, de);
      chk("majority_bit3", 32'(spins[3]), 32'(m == 9));
      cyc(2);
    end

    // Zero window behaves as one sample
    do_start(0, e); wait_done(10, de);
    chk("lat_win0", 32'(de - e + 1), 32'd3);
    cyc(2);
    rd(A + 32'd8, d); chk("window_one", d, 32'd1);

    // start held through busy and the done cycle must yield a single measurement
    osc_in = 8'h81; cyc(3);
    pulses = 0;
    do_start(4, e);
    start = 1'b1; window_len = 4;
    for (int c = 0; c < 20; c++) begin
      cyc(1);
      if (done) begin pulses++; cyc(1); break; end
    end
    start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cyc(1);
      if (done) pulses++;
    end
    chk("one_done", 32'(pulses), 32'd1);

    // Register reads
    rd(A + 32'd4, d);
    chk("sticky_set", 32'(d[2]), 32'd1);
    chk("status_idle", 32'(d[1:0]), 32'd0);
    rd(A + 32'd4, d);
    chk("sticky_clr", 32'(d[2]), 32'd0);
    rd(A + 32'h100, d);
    chk("unmapped", d, 32'd0);

    rd_en = 1'b1; rd_addr = A;
    cyc(1);
    chk("b2b_v0", 32'(rd_valid), 32'd1);
    chk("b2b_d0", rd_data, 32'h7E);
    rd_addr = A + 32'd8;
    cyc(1);
    rd_en = 1'b0;
    chk("b2b_v1", 32'(rd_valid), 32'd1);
    chk("b2b_d1", rd_data, 32'd4);
    cyc(1);
    chk("b2b_end", 32'(rd_valid), 32'd0);
    cyc(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
